// File: rtl/jtkcpu_stkseq_if.sv
// Byte-wide memory bus between the stack sequencer (master) and the memory arbiter (slave).
interface jtkcpu_stkseq_if #(
  parameter int AW = 16
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dout;
  logic [7:0]    bus_din;
  logic          bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/jtkcpu_stkseq.sv
// KCPU push/pull stack sequencer: walks a register mask and moves each selected
// register byte by byte between the register file and the stack over a req/ack bus.
//
// state | meaning
// IDLE  | waiting for start
// NEXT  | pick next register from remaining mask, or finish
// XFER  | one byte transfer on the bus, held until ack
// DONE  | one-cycle completion strobe
module jtkcpu_stkseq #(
  parameter  int NREG = 8,
  parameter  int AW   = 16,
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 start,
  input  logic                 pull,
  input  logic [NREG-1:0]      mask,
  input  logic [NREG-1:0]      wide,
  input  logic [AW-1:0]        sp_in,
  input  logic [NREG*16-1:0]   regs,
  jtkcpu_stkseq_if.master      bus,
  output logic                 ld_en,
  output logic [IW-1:0]        ld_idx,
  output logic                 ld_hi,
  output logic [7:0]           ld_data,
  output logic [AW-1:0]        sp_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, NEXT, XFER, DONE} state_t;

  state_t         state, state_nx;
  logic           pull_r;
  logic [NREG-1:0] mask_r, wide_r;
  logic [AW-1:0]  sp_r;
  logic [IW-1:0]  idx_r, sel_idx;
  logic           hi_r, first_r;
  logic           last_byte;
  logic [IW+3:0]  byte_ofs;

  // push takes the highest set bit, pull the lowest, so pull undoes push
  always_comb begin
    sel_idx = '0;
    if (pull_r) begin
      for (int i = NREG-1; i >= 0; i--)
        if (mask_r[i]) sel_idx = IW'(i);
    end else begin
      for (int i = 0; i < NREG; i++)
        if (mask_r[i]) sel_idx = IW'(i);
    end
  end

  assign last_byte = !(wide_r[idx_r] && first_r);
  assign byte_ofs  = {idx_r, hi_r, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cen && start) state_nx = NEXT;
      NEXT: if (cen) state_nx = (mask_r == '0) ? DONE : XFER;
      XFER: if (cen && bus.bus_ack && last_byte) state_nx = NEXT;
      DONE: if (cen) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pull_r  <= 1'b0;
      mask_r  <= '0;
      wide_r  <= '0;
      sp_r    <= '0;
      idx_r   <= '0;
      hi_r    <= 1'b0;
      first_r <= 1'b0;
      ld_en   <= 1'b0;
      ld_idx  <= '0;
      ld_hi   <= 1'b0;
      ld_data <= '0;
    end else if (cen) begin
      ld_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pull_r <= pull;
          mask_r <= mask;
          wide_r <= wide;
          sp_r   <= sp_in;
        end
        NEXT: if (mask_r != '0) begin
          idx_r   <= sel_idx;
          hi_r    <= pull_r & wide_r[sel_idx];
          first_r <= 1'b1;
        end
        XFER: if (bus.bus_ack) begin
          sp_r <= pull_r ? sp_r + AW'(1) : sp_r - AW'(1);
          if (pull_r) begin
            ld_en   <= 1'b1;
            ld_idx  <= idx_r;
            ld_hi   <= hi_r;
            ld_data <= bus.bus_din;
          end
          if (!last_byte) begin
            first_r <= 1'b0;
            hi_r    <= ~hi_r;
          end else begin
            mask_r[idx_r] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.bus_req  = 1'b0;
    bus.bus_we   = 1'b0;
    bus.bus_addr = '0;
    bus.bus_dout = '0;
    busy         = (state != IDLE);
    done         = (state == DONE);
    if (state == XFER) begin
      bus.bus_req  = 1'b1;
      bus.bus_we   = !pull_r;
      // push pre-decrements, pull post-increments
      bus.bus_addr = pull_r ? sp_r : sp_r - AW'(1);
      bus.bus_dout = pull_r ? 8'h00 : regs[byte_ofs +: 8];
    end
  end

  assign sp_out = sp_r;

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Directed bench for jtkcpu_stkseq: memory/ack responder plus linear check sequence.
module tb_jtkcpu_stkseq;
  localparam int NREG = 8;
  localparam int AW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b1;
  logic          start = 1'b0;
  logic          pull = 1'b0;
  logic [7:0]    mask = '0;
  logic [7:0]    wide = '0;
  logic [15:0]   sp_in = '0;
  logic [127:0]  regs = '0;
  logic          ld_en, ld_hi, busy, done;
  logic [2:0]    ld_idx;
  logic [7:0]    ld_data;
  logic [15:0]   sp_out;

  jtkcpu_stkseq_if #(.AW(AW)) bus ();

  jtkcpu_stkseq #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .pull(pull),
    .mask(mask), .wide(wide), .sp_in(sp_in), .regs(regs), .bus(bus),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_hi(ld_hi), .ld_data(ld_data),
    .sp_out(sp_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  logic cen_tog = 1'b0;

  logic [7:0]  mem [0:65535];
  int          wr_n = 0, ld_n = 0, done_n = 0, req_n = 0, cyc = 0;
  int          cyc_start = 0, cyc_done = 0, unstable = 0;
  logic [15:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  logic [2:0]  lg_idx  [0:63];
  logic        lg_hi   [0:63];
  logic [7:0]  lg_data [0:63];
  logic        prev_req = 1'b0, prev_we = 1'b0, prev_take = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_dout = '0;

  // responder: drives cen, bus_ack, bus_din on the falling edge
  int  wait_cnt = 0;
  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_din = 8'h00;
  end
  always @(negedge clk) begin
    logic consumed;
    consumed = bus.bus_ack && cen;
    cen = cen_tog ? ~cen : 1'b1;
    if (rst || !bus.bus_req || consumed) wait_cnt = 0;
    if (!rst && bus.bus_req && wait_cnt >= ack_delay) begin
      bus.bus_ack = 1'b1;
      bus.bus_din = mem[bus.bus_addr];
    end else begin
      bus.bus_ack = 1'b0;
      if (bus.bus_req) wait_cnt++;
    end
  end

  // observer: memory writes, load strobes, done pulses, bus stability
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.bus_req) req_n++;
      if (bus.bus_req && prev_req && !prev_take &&
          (bus.bus_addr !== prev_addr || bus.bus_dout !== prev_dout || bus.bus_we !== prev_we))
        unstable++;
      if (cen && bus.bus_req && bus.bus_ack && bus.bus_we) begin
        mem[bus.bus_addr] = bus.bus_dout;
        wr_addr[wr_n % 64] = bus.bus_addr;
        wr_data[wr_n % 64] = bus.bus_dout;
        wr_n++;
      end
      if (cen && ld_en) begin
        lg_idx[ld_n % 64]  = ld_idx;
        lg_hi[ld_n % 64]   = ld_hi;
        lg_data[ld_n % 64] = ld_data;
        ld_n++;
      end
      if (cen && done) begin
        done_n++;
        cyc_done = cyc;
      end
      if (cen && start && !busy) cyc_start = cyc;
    end
    prev_req  = bus.bus_req && !rst;
    prev_we   = bus.bus_we;
    prev_addr = bus.bus_addr;
    prev_dout = bus.bus_dout;
    prev_take = bus.bus_ack && cen;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic p, input logic [7:0] m, input logic [7:0] w, input logic [15:0] sp);
    int n;
    @(negedge clk);
    pull = p; mask = m; wide = w; sp_in = sp; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 100);
    check("start_accepted", busy, 1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_n == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_n != d0, 1);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_cleared", busy, 0);
  endtask

  task automatic check_wr(input string tag, input int k, input logic [15:0] a, input logic [7:0] d);
    check({tag, "_addr"}, wr_addr[k % 64], a);
    check({tag, "_data"}, wr_data[k % 64], d);
  endtask

  task automatic check_ld(input string tag, input int k, input logic [2:0] i, input logic h, input logic [7:0] d);
    check({tag, "_idx"},  lg_idx[k % 64],  i);
    check({tag, "_hi"},   lg_hi[k % 64],   h);
    check({tag, "_data"}, lg_data[k % 64], d);
  endtask

  initial begin
    int w0, l0, d0, r0, u0, n;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_flags", {bus.bus_req, bus.bus_we, ld_en, ld_hi, busy, done}, 0);
    check("rst_addr", bus.bus_addr, 0);
    check("rst_dout", bus.bus_dout, 0);
    check("rst_ld", {ld_idx, ld_data}, 0);
    check("rst_sp", sp_out, 0);
    rst = 1'b0;

    // push r7 (wide 0x1234) and r0 (8-bit 0x56)
    regs = {8{16'hEEEE}};
    regs[16*7 +: 16] = 16'h1234;
    regs[16*0 +: 16] = 16'h0056;
    w0 = wr_n; d0 = done_n;
    go(1'b0, 8'h81, 8'h80, 16'h0100);
    wait_done(d0);
    check("push_count", wr_n - w0, 3);
    check_wr("push_b0", w0,   16'h00FF, 8'h34);
    check_wr("push_b1", w0+1, 16'h00FE, 8'h12);
    check_wr("push_b2", w0+2, 16'h00FD, 8'h56);
    check("push_sp", sp_out, 16'h00FD);
    check("push_done_pulses", done_n - d0, 1);
    check("push_latency", cyc_done - cyc_start, 7);

    // pull the same mask back
    l0 = ld_n; d0 = done_n;
    go(1'b1, 8'h81, 8'h80, 16'h00FD);
    wait_done(d0);
    check("pull_count", ld_n - l0, 3);
    check_ld("pull_l0", l0,   3'd0, 1'b0, 8'h56);
    check_ld("pull_l1", l0+1, 3'd7, 1'b1, 8'h12);
    check_ld("pull_l2", l0+2, 3'd7, 1'b0, 8'h34);
    check("pull_sp", sp_out, 16'h0100);

    // empty mask
    r0 = req_n; d0 = done_n;
    go(1'b0, 8'h00, 8'hFF, 16'h1234);
    wait_done(d0);
    check("empty_no_req", req_n - r0, 0);
    check("empty_latency", cyc_done - cyc_start, 2);
    check("empty_sp", sp_out, 16'h1234);
    check("empty_done_pulses", done_n - d0, 1);

    // SP wrap: push at 0x0000, pull at 0xFFFF
    regs[16*1 +: 16] = 16'h77AB;
    w0 = wr_n; d0 = done_n;
    go(1'b0, 8'h02, 8'h00, 16'h0000);
    wait_done(d0);
    check("wrap_push_count", wr_n - w0, 1);
    check_wr("wrap_push", w0, 16'hFFFF, 8'hAB);
    check("wrap_push_sp", sp_out, 16'hFFFF);
    l0 = ld_n; d0 = done_n;
    go(1'b1, 8'h02, 8'h00, 16'hFFFF);
    wait_done(d0);
    check("wrap_pull_count", ld_n - l0, 1);
    check_ld("wrap_pull", l0, 3'd1, 1'b0, 8'hAB);
    check("wrap_pull_sp", sp_out, 16'h0000);

    // slow ack, toggling cen, start re-pulsed while busy
    regs[16*7 +: 16] = 16'hBEEF;
    regs[16*0 +: 16] = 16'h0011;
    ack_delay = 5; cen_tog = 1'b1;
    w0 = wr_n; l0 = ld_n; d0 = done_n; u0 = unstable;
    go(1'b0, 8'h81, 8'h80, 16'h0200);
    repeat (6) @(negedge clk);
    pull = 1'b1; mask = 8'h02; wide = 8'h00; sp_in = 16'h0000; start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(d0);
    check("slow_count", wr_n - w0, 3);
    check_wr("slow_b0", w0,   16'h01FF, 8'hEF);
    check_wr("slow_b1", w0+1, 16'h01FE, 8'hBE);
    check_wr("slow_b2", w0+2, 16'h01FD, 8'h11);
    check("slow_sp", sp_out, 16'h01FD);
    check("slow_done_pulses", done_n - d0, 1);
    check("slow_no_loads", ld_n - l0, 0);
    check("slow_bus_stable", unstable - u0, 0);
    cen_tog = 1'b0;
    repeat (2) @(negedge clk);

    // reset during second byte of a wide push
    regs[16*7 +: 16] = 16'h1234;
    regs[16*0 +: 16] = 16'h0056;
    w0 = wr_n;
    go(1'b0, 8'h80, 8'h80, 16'h0400);
    n = 0;
    while (wr_n == w0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_byte", wr_n - w0, 1);
    repeat (2) @(negedge clk);
    check("abort_in_xfer", bus.bus_req, 1);
    check("abort_second_addr", bus.bus_addr, 16'h03FE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_flags", {bus.bus_req, bus.bus_we, ld_en, ld_hi, busy, done}, 0);
    check("abort_addr_dout", {bus.bus_addr, bus.bus_dout}, 0);
    check("abort_sp", sp_out, 0);
    repeat (8) @(negedge clk);
    check("abort_no_more_writes", wr_n - w0, 1);
    rst = 1'b0;
    ack_delay = 0;
    w0 = wr_n; d0 = done_n;
    go(1'b0, 8'h81, 8'h80, 16'h0300);
    wait_done(d0);
    check("after_rst_count", wr_n - w0, 3);
    check_wr("after_rst_b0", w0,   16'h02FF, 8'h34);
    check_wr("after_rst_b1", w0+1, 16'h02FE, 8'h12);
    check_wr("after_rst_b2", w0+2, 16'h02FD, 8'h56);
    check("after_rst_sp", sp_out, 16'h02FD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
